// File: rtl/matmul_sequencer.sv
// Command-driven tile sequencer for the systolic array: takes one matmul command on a
// valid/ready handshake and walks weight load, per-tile compute and writeback on its own.
module matmul_sequencer #(
    parameter int WIDTH_HEIGHT   = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int TILE_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [TILE_W-1:0]                  cmd_tiles,
    input  logic [ADDR_WIDTH-1:0]              cmd_in_base,
    input  logic [ADDR_WIDTH-1:0]              cmd_in_stride,
    input  logic [ADDR_WIDTH-1:0]              cmd_out_base,
    input  logic [ADDR_WIDTH-1:0]              cmd_out_stride,
    input  logic                               cmd_reuse_w,
    input  logic                               abort,
    output logic                               mem_to_fifo,
    input  logic                               mem_to_fifo_done,
    output logic                               fifo_to_arr,
    input  logic                               fifo_to_arr_done,
    output logic [WIDTH_HEIGHT-1:0]            weight_write,
    output logic                               active,
    input  logic                               output_done,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] inputMem_rd_addr_base,
    output logic [WIDTH_HEIGHT*ADDR_WIDTH-1:0] outputMem_wr_addr_base,
    output logic [TILE_W-1:0]                  tile_idx,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        PUSH_W = 3'd2,
        RUN    = 3'd3,
        NEXT   = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_ZERO;
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TILE_W-1:0] TILE_ONE = TILE_W'(1'b1);

    state_t                  state_r, fsm_next_s, next_s;
    logic [CNT_W-1:0]        wait_cnt_r;
    logic [TILE_W-1:0]       tiles_r, tile_idx_r;
    logic [ADDR_WIDTH-1:0]   in_base_r, out_base_r, in_stride_r, out_stride_r;
    logic                    cmd_ready_r, busy_r, done_r, error_r;
    logic                    mem_to_fifo_r, fifo_to_arr_r, active_r;
    logic [WIDTH_HEIGHT-1:0] weight_write_r;
    logic                    accept_s, first_s, expired_s, advance_s;

    assign accept_s  = cmd_valid && cmd_ready_r;
    assign first_s   = (wait_cnt_r == CNT_ZERO);
    assign expired_s = TO_EN && (wait_cnt_r == CNT_LAST);
    assign advance_s = (state_r == NEXT) && (next_s == RUN);

    // Next-state decode; done inputs only count from the second cycle of a wait state.
    always_comb begin
        fsm_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s)                  fsm_next_s = IDLE;
                else if (cmd_tiles == {TILE_W{1'b0}}) fsm_next_s = FIN;
                else if (cmd_reuse_w)           fsm_next_s = RUN;
                else                            fsm_next_s = LOAD_W;
            end
            LOAD_W: begin
                if (!first_s && mem_to_fifo_done) fsm_next_s = PUSH_W;
                else if (expired_s)               fsm_next_s = ERR;
                else                              fsm_next_s = LOAD_W;
            end
            PUSH_W: begin
                if (!first_s && fifo_to_arr_done) fsm_next_s = RUN;
                else if (expired_s)               fsm_next_s = ERR;
                else                              fsm_next_s = PUSH_W;
            end
            RUN: begin
                if (!first_s && output_done) fsm_next_s = NEXT;
                else if (expired_s)          fsm_next_s = ERR;
                else                         fsm_next_s = RUN;
            end
            NEXT: begin
                if (tile_idx_r == tiles_r - TILE_ONE) fsm_next_s = FIN;
                else                                  fsm_next_s = RUN;
            end
            FIN:     fsm_next_s = IDLE;
            ERR:     fsm_next_s = IDLE;
            default: fsm_next_s = IDLE;
        endcase
        next_s = (abort && (state_r != IDLE)) ? IDLE : fsm_next_s;
    end

    // State, wait counter and strobes, registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= IDLE;
            wait_cnt_r     <= CNT_ZERO;
            cmd_ready_r    <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            mem_to_fifo_r  <= 1'b0;
            fifo_to_arr_r  <= 1'b0;
            active_r       <= 1'b0;
            weight_write_r <= {WIDTH_HEIGHT{1'b0}};
        end else begin
            state_r        <= next_s;
            if (next_s != state_r)         wait_cnt_r <= CNT_ZERO;
            else if (wait_cnt_r != CNT_MAX) wait_cnt_r <= wait_cnt_r + CNT_ONE;
            else                            wait_cnt_r <= wait_cnt_r;
            cmd_ready_r    <= (next_s == IDLE);
            busy_r         <= (next_s != IDLE);
            done_r         <= (next_s == FIN);
            mem_to_fifo_r  <= (next_s == LOAD_W) && (state_r != LOAD_W);
            fifo_to_arr_r  <= (next_s == PUSH_W) && (state_r != PUSH_W);
            active_r       <= (next_s == RUN) && (state_r != RUN);
            weight_write_r <= (next_s == PUSH_W) ? {WIDTH_HEIGHT{1'b1}} : {WIDTH_HEIGHT{1'b0}};
        end
    end

    // Command latch and per-tile address stepping; bases wrap modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tiles_r      <= {TILE_W{1'b0}};
            tile_idx_r   <= {TILE_W{1'b0}};
            in_base_r    <= {ADDR_WIDTH{1'b0}};
            out_base_r   <= {ADDR_WIDTH{1'b0}};
            in_stride_r  <= {ADDR_WIDTH{1'b0}};
            out_stride_r <= {ADDR_WIDTH{1'b0}};
        end else if (accept_s) begin
            tiles_r      <= cmd_tiles;
            tile_idx_r   <= {TILE_W{1'b0}};
            in_base_r    <= cmd_in_base;
            out_base_r   <= cmd_out_base;
            in_stride_r  <= cmd_in_stride;
            out_stride_r <= cmd_out_stride;
        end else if (advance_s) begin
            tile_idx_r   <= tile_idx_r + TILE_ONE;
            in_base_r    <= in_base_r + in_stride_r;
            out_base_r   <= out_base_r + out_stride_r;
        end else begin
            tile_idx_r   <= tile_idx_r;
            in_base_r    <= in_base_r;
            out_base_r   <= out_base_r;
        end
    end

    // Sticky timeout flag: cleared by a new command, set on the way into ERR.
    always_ff @(posedge clk) begin
        if (!reset)               error_r <= 1'b0;
        else if (accept_s)        error_r <= 1'b0;
        else if (next_s == ERR)   error_r <= 1'b1;
        else                      error_r <= error_r;
    end

    assign cmd_ready              = cmd_ready_r;
    assign busy                   = busy_r;
    assign done                   = done_r;
    assign error                  = error_r;
    assign mem_to_fifo            = mem_to_fifo_r;
    assign fifo_to_arr            = fifo_to_arr_r;
    assign active                 = active_r;
    assign weight_write           = weight_write_r;
    assign tile_idx               = tile_idx_r;
    assign inputMem_rd_addr_base  = {WIDTH_HEIGHT{in_base_r}};
    assign outputMem_wr_addr_base = {WIDTH_HEIGHT{out_base_r}};

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: a small datapath model answers each strobe
// three cycles later, and scenario tasks check strobes, addresses and status.
module tb_matmul_sequencer;

    localparam int WH = 16;
    localparam int AW = 8;
    localparam int TW = 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_reuse_w = 1'b0, abort = 1'b0;
    logic [TW-1:0] cmd_tiles = '0;
    logic [AW-1:0] cmd_in_base = '0, cmd_in_stride = '0, cmd_out_base = '0, cmd_out_stride = '0;
    logic mem_to_fifo, fifo_to_arr, active, busy, done, error;
    logic mem_to_fifo_done = 1'b0, fifo_to_arr_done = 1'b0, output_done = 1'b0;
    logic [WH-1:0] weight_write;
    logic [WH*AW-1:0] in_bus, out_bus;
    logic [TW-1:0] tile_idx;

    int errors = 0, checks = 0;
    int cyc = 0, m2f_n = 0, f2a_n = 0, act_n = 0, done_n = 0, ww_n = 0, ww_bad = 0;
    int m2f_t = 0, f2a_t = 0, act_t = 0, ww_rise_t = 0;
    logic [AW-1:0] act_in [64];
    logic [AW-1:0] act_out [64];
    logic [TW-1:0] act_tile [64];
    bit            act_uni [64];
    logic [WH-1:0] ww_prev = '0;
    int cd_m = 0, cd_f = 0, cd_o = 0;
    bit resp_m_en = 1'b1;

    always #5 clk = ~clk;

    matmul_sequencer #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW), .TILE_W(TW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_tiles(cmd_tiles), .cmd_in_base(cmd_in_base), .cmd_in_stride(cmd_in_stride),
        .cmd_out_base(cmd_out_base), .cmd_out_stride(cmd_out_stride), .cmd_reuse_w(cmd_reuse_w),
        .abort(abort), .mem_to_fifo(mem_to_fifo), .mem_to_fifo_done(mem_to_fifo_done),
        .fifo_to_arr(fifo_to_arr), .fifo_to_arr_done(fifo_to_arr_done),
        .weight_write(weight_write), .active(active), .output_done(output_done),
        .inputMem_rd_addr_base(in_bus), .outputMem_wr_addr_base(out_bus),
        .tile_idx(tile_idx), .busy(busy), .done(done), .error(error)
    );

    function automatic bit uniform(input logic [WH*AW-1:0] bus);
        for (int i = 1; i < WH; i++)
            if (bus[i*AW +: AW] != bus[AW-1:0]) return 1'b0;
        return 1'b1;
    endfunction

    // Datapath model: each done returns three cycles after its strobe.
    initial forever begin
        @(negedge clk);
        mem_to_fifo_done = 1'b0; fifo_to_arr_done = 1'b0; output_done = 1'b0;
        if (mem_to_fifo) cd_m = 3;
        else if (cd_m > 0) begin cd_m--; if (cd_m == 0 && resp_m_en) mem_to_fifo_done = 1'b1; end
        if (fifo_to_arr) cd_f = 3;
        else if (cd_f > 0) begin cd_f--; if (cd_f == 0) fifo_to_arr_done = 1'b1; end
        if (active) cd_o = 3;
        else if (cd_o > 0) begin cd_o--; if (cd_o == 0) output_done = 1'b1; end
    end

    // Output monitor: pulse counts, cycle stamps and per-tile address snapshots.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (mem_to_fifo) begin m2f_n++; m2f_t = cyc; end
        if (fifo_to_arr) begin f2a_n++; f2a_t = cyc; end
        if (active) begin
            if (act_n < 64) begin
                act_in[act_n] = in_bus[AW-1:0];
                act_out[act_n] = out_bus[AW-1:0];
                act_tile[act_n] = tile_idx;
                act_uni[act_n] = uniform(in_bus) && uniform(out_bus);
            end
            act_n++; act_t = cyc;
        end
        if (weight_write != '0) ww_n++;
        if (weight_write != '0 && weight_write != {WH{1'b1}}) ww_bad++;
        if (weight_write != '0 && ww_prev == '0) ww_rise_t = cyc;
        ww_prev = weight_write;
        if (done) done_n++;
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic send(input logic [TW-1:0] t, input logic [AW-1:0] ib, input logic [AW-1:0] is,
                        input logic [AW-1:0] ob, input logic [AW-1:0] os, input logic r);
        cmd_tiles = t; cmd_in_base = ib; cmd_in_stride = is;
        cmd_out_base = ob; cmd_out_stride = os; cmd_reuse_w = r; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 1;
        while (!cmd_ready && n < 300) begin step(); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL wait_idle cmd_ready=%b after %0d cycles, want 1", cmd_ready, n); end
    endtask

    task automatic test_reset();
        reset = 1'b0; step(); step();
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        checks++;
        if ({busy, done, error, mem_to_fifo, fifo_to_arr, active} !== 6'b0) begin
            errors++; $display("FAIL reset_flags got %b want 000000", {busy, done, error, mem_to_fifo, fifo_to_arr, active});
        end
        checks++;
        if (weight_write !== '0 || tile_idx !== '0 || in_bus !== '0 || out_bus !== '0) begin
            errors++; $display("FAIL reset_buses ww=%h tile=%h in=%h out=%h want 0", weight_write, tile_idx, in_bus, out_bus);
        end
        reset = 1'b1; step();
    endtask

    task automatic test_single();
        int bm = m2f_n, bf = f2a_n, ba = act_n, bd = done_n, bw = ww_n, n;
        send(8'd1, 8'h10, 8'h00, 8'h20, 8'h00, 1'b0);
        wait_idle(n); step();
        checks++;
        if (n != 15) begin errors++; $display("FAIL single_latency got %0d want 15", n); end
        checks++;
        if (m2f_n - bm != 1 || f2a_n - bf != 1 || act_n - ba != 1) begin
            errors++; $display("FAIL single_pulses m2f=%0d f2a=%0d act=%0d want 1/1/1", m2f_n - bm, f2a_n - bf, act_n - ba);
        end
        checks++;
        if (f2a_t - m2f_t != 4 || act_t - f2a_t != 4) begin
            errors++; $display("FAIL single_order gaps %0d/%0d want 4/4", f2a_t - m2f_t, act_t - f2a_t);
        end
        checks++;
        if (ww_n - bw != 4 || ww_rise_t != f2a_t || ww_bad != 0) begin
            errors++; $display("FAIL single_ww cycles=%0d rise=%0d f2a=%0d bad=%0d want 4,rise=f2a,0", ww_n - bw, ww_rise_t, f2a_t, ww_bad);
        end
        checks++;
        if (act_in[ba] !== 8'h10 || act_out[ba] !== 8'h20 || !act_uni[ba]) begin
            errors++; $display("FAIL single_addr in=%h out=%h uni=%0d want 10/20/1", act_in[ba], act_out[ba], act_uni[ba]);
        end
        checks++;
        if (done_n - bd != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done done=%0d busy=%b want 1/0", done_n - bd, busy);
        end
    endtask

    task automatic test_multi();
        logic [AW-1:0] ein [3];
        logic [AW-1:0] eout [3];
        int bm = m2f_n, bf = f2a_n, ba = act_n, bd = done_n, n;
        ein[0] = 8'hF0; ein[1] = 8'hF8; ein[2] = 8'h00;
        eout[0] = 8'h40; eout[1] = 8'h50; eout[2] = 8'h60;
        send(8'd3, 8'hF0, 8'h08, 8'h40, 8'h10, 1'b0);
        wait_idle(n); step();
        checks++;
        if (m2f_n - bm != 1 || f2a_n - bf != 1 || act_n - ba != 3) begin
            errors++; $display("FAIL multi_pulses m2f=%0d f2a=%0d act=%0d want 1/1/3", m2f_n - bm, f2a_n - bf, act_n - ba);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_in[ba+i] !== ein[i] || act_out[ba+i] !== eout[i] || act_tile[ba+i] !== TW'(i) || !act_uni[ba+i]) begin
                errors++; $display("FAIL multi_tile%0d in=%h out=%h idx=%0d uni=%0d want %h/%h/%0d/1",
                                   i, act_in[ba+i], act_out[ba+i], act_tile[ba+i], act_uni[ba+i], ein[i], eout[i], i);
            end
        end
        checks++;
        if (done_n - bd != 1) begin errors++; $display("FAIL multi_done got %0d want 1", done_n - bd); end
    endtask

    task automatic test_reuse();
        int bm = m2f_n, bf = f2a_n, ba = act_n, bd = done_n, bw = ww_n, n;
        send(8'd2, 8'h05, 8'h01, 8'h80, 8'h02, 1'b1);
        wait_idle(n); step();
        checks++;
        if (m2f_n - bm != 0 || f2a_n - bf != 0 || ww_n - bw != 0) begin
            errors++; $display("FAIL reuse_weights m2f=%0d f2a=%0d ww=%0d want 0/0/0", m2f_n - bm, f2a_n - bf, ww_n - bw);
        end
        checks++;
        if (act_n - ba != 2 || done_n - bd != 1) begin
            errors++; $display("FAIL reuse_counts act=%0d done=%0d want 2/1", act_n - ba, done_n - bd);
        end
        checks++;
        if (act_in[ba] !== 8'h05 || act_in[ba+1] !== 8'h06 || act_out[ba] !== 8'h80 || act_out[ba+1] !== 8'h82) begin
            errors++; $display("FAIL reuse_addr in=%h,%h out=%h,%h want 05,06 80,82", act_in[ba], act_in[ba+1], act_out[ba], act_out[ba+1]);
        end
    endtask

    task automatic test_zero_tiles();
        int bm = m2f_n, bf = f2a_n, ba = act_n, bd = done_n, n;
        send(8'd0, 8'h11, 8'h01, 8'h22, 8'h01, 1'b0);
        wait_idle(n); step();
        checks++;
        if (n != 2 || done_n - bd != 1) begin errors++; $display("FAIL zero_done cycles=%0d done=%0d want 2/1", n, done_n - bd); end
        checks++;
        if (m2f_n - bm + f2a_n - bf + act_n - ba != 0) begin
            errors++; $display("FAIL zero_strobes got %0d want 0", m2f_n - bm + f2a_n - bf + act_n - ba);
        end
    endtask

    task automatic test_timeout();
        int bm = m2f_n, bf = f2a_n, bd = done_n, n;
        resp_m_en = 1'b0;
        send(8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle(n);
        checks++;
        if (n != TO + 2) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", n, TO + 2); end
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL timeout_error error=%b busy=%b want 1/0", error, busy); end
        checks++;
        if (done_n - bd != 0 || m2f_n - bm != 1 || f2a_n - bf != 0) begin
            errors++; $display("FAIL timeout_pulses done=%0d m2f=%0d f2a=%0d want 0/1/0", done_n - bd, m2f_n - bm, f2a_n - bf);
        end
        resp_m_en = 1'b1;
        step(); step();
        send(8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL timeout_clear error=%b want 0", error); end
        wait_idle(n);
    endtask

    task automatic test_abort();
        int ba = act_n, bd = done_n, k = 0;
        send(8'd4, 8'h00, 8'h04, 8'h00, 8'h04, 1'b0);
        while (!(active === 1'b1 && tile_idx == 8'd1) && k < 200) begin step(); k++; end
        checks++;
        if (k >= 200) begin errors++; $display("FAIL abort_reach tile1 not reached tile=%0d want 1", tile_idx); end
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if ({busy, mem_to_fifo, fifo_to_arr, active, done} !== 5'b0 || weight_write !== '0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL abort_idle flags=%b ww=%h ready=%b want 00000/0/1",
                               {busy, mem_to_fifo, fifo_to_arr, active, done}, weight_write, cmd_ready);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (done_n - bd != 0 || act_n - ba != 2 || busy !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL abort_after done=%0d act=%0d busy=%b error=%b want 0/2/0/0", done_n - bd, act_n - ba, busy, error);
        end
    endtask

    task automatic test_reset_mid();
        int bd = done_n, k = 0;
        send(8'd2, 8'h33, 8'h01, 8'h44, 8'h01, 1'b0);
        while (weight_write == '0 && k < 200) begin step(); k++; end
        checks++;
        if (k >= 200) begin errors++; $display("FAIL rstmid_reach ww=%h want nonzero", weight_write); end
        reset = 1'b0; step();
        checks++;
        if ({busy, done, error, mem_to_fifo, fifo_to_arr, active} !== 6'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_flags got %b ready=%b want 000000/1", {busy, done, error, mem_to_fifo, fifo_to_arr, active}, cmd_ready);
        end
        checks++;
        if (weight_write !== '0 || tile_idx !== '0 || in_bus !== '0 || out_bus !== '0) begin
            errors++; $display("FAIL rstmid_buses ww=%h tile=%h in=%h out=%h want 0", weight_write, tile_idx, in_bus[AW-1:0], out_bus[AW-1:0]);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (done_n - bd != 0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_after done=%0d busy=%b want 0/0", done_n - bd, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_reuse();
        test_zero_tiles();
        test_timeout();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Parametrised command-driven sequencer that replaces the host-toggled strobes on the systolic-array top level.
- Accepts one matrix-multiply command on a valid/ready handshake and steps through the weight phase, the input/compute phase and the output phase.
- Walks tiles on its own: drives mem_to_fifo, fifo_to_arr, weight_write and active, and supplies per-tile input and output base addresses.
- Sits between the host interconnect and the array datapath; the datapath's done signals come back as handshakes.

Parameters:
WIDTH_HEIGHT, 16, array dimension; lane count of weight_write and of the replicated base-address buses
ADDR_WIDTH, 8, per-lane memory address width
TILE_W, 8, width of the tile count and tile index
TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for any done input; 0 disables the timeout

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept a command
cmd_tiles  in  TILE_W  number of tiles to run
cmd_in_base  in  ADDR_WIDTH  input-memory base for tile 0
cmd_in_stride  in  ADDR_WIDTH  input base increment per tile
cmd_out_base  in  ADDR_WIDTH  output-memory base for tile 0
cmd_out_stride  in  ADDR_WIDTH  output base increment per tile
cmd_reuse_w  in  1  skip the weight phase; weights are already resident in the array
abort  in  1  synchronous abort
mem_to_fifo  out  1  one-cycle start pulse for weightMem-to-FIFO transfer
mem_to_fifo_done  in  1  transfer complete
fifo_to_arr  out  1  one-cycle start pulse for FIFO-to-array transfer
fifo_to_arr_done  in  1  transfer complete
weight_write  out  WIDTH_HEIGHT  weight commit enables to the array
active  out  1  one-cycle compute start pulse
output_done  in  1  output writeback complete
inputMem_rd_addr_base  out  WIDTH_HEIGHT*ADDR_WIDTH  current input base, replicated to every lane
outputMem_wr_addr_base  out  WIDTH_HEIGHT*ADDR_WIDTH  current output base, replicated to every lane
tile_idx  out  TILE_W  index of the tile in progress
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
error  out  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All strobes, weight_write, tile_idx, both address buses, busy, done and error go to 0.
  - cmd_ready goes to 1.
- cmd_ready is 1 only in IDLE.
- Accept occurs when cmd_valid && cmd_ready.
- On accept:
  - Latch tiles, strides and reuse flag.
  - Load in_base and out_base.
  - Clear tile_idx and error.
  - Set busy in the next cycle.
- States: IDLE, LOAD_W, PUSH_W, RUN, NEXT, FIN, ERR.
- Transition after accept:
  - cmd_tiles==0 → FIN.
  - cmd_reuse_w==1 → RUN.
  - Otherwise → LOAD_W.
- LOAD_W:
  - mem_to_fifo is high for exactly the first cycle in the state.
  - mem_to_fifo_done is ignored in that first cycle and sampled from the following cycle.
  - Done seen → PUSH_W.
- PUSH_W:
  - fifo_to_arr pulses in the first cycle.
  - weight_write is all ones for every cycle in PUSH_W and 0 otherwise.
  - fifo_to_arr_done seen (from the second cycle) → RUN.
- RUN:
  - active pulses in the first cycle.
  - output_done seen (from the second cycle) → NEXT.
- NEXT (one cycle):
  - If tile_idx == tiles-1 → FIN.
  - Otherwise: tile_idx+1; in_base += in_stride; out_base += out_stride, both modulo 2^ADDR_WIDTH; then → RUN.
  - Weights load only once per command.
- FIN: done pulses high for one cycle, then → IDLE. busy is 0 from the IDLE cycle.
- Address buses change only on accept and in NEXT, and are stable through every RUN.
- Timeout:
  - A wait counter clears on entry to each wait state and increments every cycle in it.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no done → ERR.
  - ERR lasts one cycle: sets error, then → IDLE with no done pulse.
  - error stays high until the next accept or reset.
- abort:
  - In any non-IDLE state: next state is IDLE, strobes and weight_write drop the same edge, no done pulse, error unchanged.
  - abort has priority over done inputs and the timeout.
  - In IDLE, abort is ignored; an accept in the same cycle is still taken.
- Stray done inputs in IDLE, FIN or NEXT are ignored.
- Reset mid-command overrides everything, with the values listed above.

Test Plan:
- Reset, then cmd tiles=1, in_base=0x10, out_base=0x20, reuse=0; return each done 3 cycles after its strobe → mem_to_fifo, fifo_to_arr and active each pulse once in order; weight_write=0xFFFF only during PUSH_W; buses hold 0x10/0x20 in every lane; done pulses once; busy falls.
- tiles=3, in_base=0xF0, in_stride=0x08, out_stride=0x10, reuse=0 → one weight load; active pulses 3 times; input base 0xF0, 0xF8, 0x00 (wrap); output base +0x10 per tile; tile_idx 0..2.
- reuse=1, tiles=2 → no mem_to_fifo or fifo_to_arr pulses; weight_write stays 0; two active pulses; done once.
- tiles=0 → accepted; done two cycles later; no strobes.
- TIMEOUT_CYCLES=8, hold mem_to_fifo_done low → ERR after 8 wait cycles; error=1; no done; cmd_ready returns; next accept clears error.
- abort asserted mid-RUN on tile 1 of 4, and separately reset pulled low mid-PUSH_W → IDLE next cycle; strobes and weight_write 0; no done; outputs at reset values for the reset case.
